// File: rtl/mnist_frame_loader_pkg.sv
// Shared definitions for the MNIST frame RAM: image geometry, header sync bytes
// and the loader state encoding, reused by every frame-RAM client.
package mnist_frame_loader_pkg;

  localparam int IMG_DIM    = 28;
  localparam int NUM_PIXELS = IMG_DIM * IMG_DIM;
  localparam int ADDR_W     = 10;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(NUM_PIXELS - 1);

  localparam logic [23:0] TIMEOUT_CYCLES_DEFAULT = 24'd5_000_000;

  typedef enum logic [1:0] {
    S_HUNT0  = 2'd0,
    S_HUNT1  = 2'd1,
    S_PIXELS = 2'd2,
    S_CHECK  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/mnist_frame_loader_frame_timeout_counter.sv
// Idle-gap watchdog: counts enabled cycles since the last clear and flags the
// cycle in which the count sits at TERMINAL-1 with no clear pending.
module frame_timeout_counter #(
  parameter logic [23:0] TERMINAL = 24'd5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  logic [23:0] cnt_q;
  logic [23:0] cnt_d;

  // Next count: clear wins, otherwise count up while enabled and hold at terminal.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = 24'd0;
    end else if (enable && (cnt_q != (TERMINAL - 24'd1))) begin
      cnt_d = cnt_q + 24'd1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 24'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = enable && !clear && (cnt_q == (TERMINAL - 24'd1));

endmodule

// File: rtl/mnist_frame_loader.sv
// Write-side frame loader: hunts for the A5/5A header, streams 784 pixel bytes
// into Port A of the frame RAM, and publishes frame_ready only after the
// trailing 8-bit checksum matches.
module mnist_frame_loader
  import mnist_frame_loader_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [7:0]        ram_data_a,
  output logic              ram_we_a,
  output logic              frame_ready,
  output logic              frame_err,
  output logic              busy,
  output logic [7:0]        frame_count
);

  loader_state_e     state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [7:0]        csum_q, csum_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              we_q, we_d;
  logic              frame_ready_q, frame_ready_d;
  logic              frame_err_q, frame_err_d;
  logic              busy_q, busy_d;
  logic [7:0]        frame_count_q, frame_count_d;
  logic              timeout_tc;

  frame_timeout_counter #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid || (state_q == S_HUNT0)),
    .enable (state_q != S_HUNT0),
    .tc     (timeout_tc)
  );

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_HUNT0;
      index_q       <= '0;
      csum_q        <= '0;
      addr_q        <= '0;
      data_q        <= '0;
      we_q          <= 1'b0;
      frame_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;
      busy_q        <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      csum_q        <= csum_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      we_q          <= we_d;
      frame_ready_q <= frame_ready_d;
      frame_err_q   <= frame_err_d;
      busy_q        <= busy_d;
      frame_count_q <= frame_count_d;
    end
  end

  // Next-state logic: a received byte always takes priority over a timeout.
  always_comb begin
    state_d = state_q;
    if (rx_valid) begin
      unique case (state_q)
        S_HUNT0: if (rx_data == SYNC0) state_d = S_HUNT1;
        S_HUNT1: begin
          if (rx_data == SYNC1)      state_d = S_PIXELS;
          else if (rx_data != SYNC0) state_d = S_HUNT0;
        end
        S_PIXELS: if (index_q == LAST_INDEX) state_d = S_CHECK;
        S_CHECK:  state_d = S_HUNT0;
        default:  state_d = S_HUNT0;
      endcase
    end else if (timeout_tc) begin
      state_d = S_HUNT0;
    end
  end

  // Output and datapath logic: pixel writes, checksum accumulation, verdicts.
  always_comb begin
    index_d       = index_q;
    csum_d        = csum_q;
    addr_d        = addr_q;
    data_d        = data_q;
    we_d          = 1'b0;
    frame_ready_d = frame_ready_q;
    frame_err_d   = 1'b0;
    frame_count_d = frame_count_q;
    busy_d        = (state_q != S_HUNT0);
    if (rx_valid) begin
      unique case (state_q)
        S_HUNT1: begin
          if (rx_data == SYNC1) begin
            index_d = '0;
            csum_d  = '0;
          end
        end
        S_PIXELS: begin
          we_d    = 1'b1;
          addr_d  = index_q;
          data_d  = rx_data;
          csum_d  = csum_q + rx_data;
          index_d = (index_q == LAST_INDEX) ? '0 : index_q + 1'b1;
          if (index_q == '0) frame_ready_d = 1'b0;
        end
        S_CHECK: begin
          if (rx_data == csum_q) begin
            frame_ready_d = 1'b1;
            frame_count_d = frame_count_q + 8'd1;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else if (timeout_tc) begin
      frame_err_d = 1'b1;
    end
  end

  assign ram_addr_a  = addr_q;
  assign ram_data_a  = data_q;
  assign ram_we_a    = we_q;
  assign frame_ready = frame_ready_q;
  assign frame_err   = frame_err_q;
  assign busy        = busy_q;
  assign frame_count = frame_count_q;

endmodule
